// File: rtl/cy8_pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CARRY8-style 8-bit slice per stage, CO[7] registered between slices.
// Latency NSLICE cycles, one result per cycle; a stalled output freezes every stage (I_READY = O_READY | ~O_VALID).
module cy8_pipe_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic             I_SUB,
  input  logic             I_CI,
  input  logic [WIDTH-1:0] I_A,
  input  logic [WIDTH-1:0] I_B,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O_SUM,
  output logic             O_CO,
  output logic             O_OV
);

  localparam int NSLICE = WIDTH / 8;

  logic en;
  assign en      = O_READY | ~O_VALID;
  assign I_READY = en;

  // One CARRY8 slice in SINGLE_CY8 mode; returns {CO[7], O[7:0]}
  function automatic logic [8:0] carry8(input logic [7:0] di,
                                        input logic [7:0] s,
                                        input logic       ci);
    logic [7:0] o;
    logic       c;
    o = '0;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      o[i] = s[i] ^ c;
      c    = s[i] ? c : di[i];
    end
    return {c, o};
  endfunction

  for (genvar k = 0; k < NSLICE; k++) begin : g_st
    localparam int RW = 8 * (k + 1);

    logic [7:0]    a_s;
    logic [7:0]    b_s;
    logic [7:0]    s;
    logic          sub_s;
    logic          ci_s;
    logic          vld_s;
    logic [8:0]    r;
    logic          vld_q;
    logic [RW-1:0] sum_q;
    logic [RW-1:0] sum_d;

    if (k == 0) begin : g_src
      assign a_s   = I_A[7:0];
      assign b_s   = I_B[7:0];
      assign sub_s = I_SUB;
      assign ci_s  = I_CI ^ I_SUB;
      assign vld_s = I_VALID;
      assign sum_d = r[7:0];
    end else begin : g_src
      assign a_s   = g_st[k-1].g_fwd.a_q[7:0];
      assign b_s   = g_st[k-1].g_fwd.b_q[7:0];
      assign sub_s = g_st[k-1].g_fwd.sub_q;
      assign ci_s  = g_st[k-1].g_fwd.cy_q;
      assign vld_s = g_st[k-1].vld_q;
      // finished low slices ride along so all slices leave the last stage together
      assign sum_d = {r[7:0], g_st[k-1].sum_q};
    end

    assign s = a_s ^ (sub_s ? ~b_s : b_s);
    assign r = carry8(a_s, s, ci_s);

    always_ff @(posedge CLK) begin
      if (RST) begin
        vld_q <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        vld_q <= vld_s;
        sum_q <= sum_d;
      end
    end

    if (k < NSLICE - 1) begin : g_fwd
      localparam int OW = WIDTH - RW;

      logic [OW-1:0] a_q;
      logic [OW-1:0] b_q;
      logic [OW-1:0] a_d;
      logic [OW-1:0] b_d;
      logic          sub_q;
      logic          cy_q;

      // operand slices not yet consumed; slice k+1 sits in the low byte
      if (k == 0) begin : g_op
        assign a_d = I_A[WIDTH-1:8];
        assign b_d = I_B[WIDTH-1:8];
      end else begin : g_op
        assign a_d = g_st[k-1].g_fwd.a_q[OW+7:8];
        assign b_d = g_st[k-1].g_fwd.b_q[OW+7:8];
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
          cy_q  <= 1'b0;
        end else if (en) begin
          a_q   <= a_d;
          b_q   <= b_d;
          sub_q <= sub_s;
          cy_q  <= r[8];
        end
      end
    end else begin : g_last
      logic co6;
      logic co_q;
      logic ov_q;

      // CO[6] recovered from the MSB sum bit: O[7] = S[7] ^ CO[6]
      assign co6 = r[7] ^ s[7];

      always_ff @(posedge CLK) begin
        if (RST) begin
          co_q <= 1'b0;
          ov_q <= 1'b0;
        end else if (en) begin
          co_q <= r[8];
          ov_q <= co6 ^ r[8];
        end
      end
    end
  end

  assign O_VALID = g_st[NSLICE-1].vld_q;
  assign O_SUM   = g_st[NSLICE-1].sum_q;
  assign O_CO    = g_st[NSLICE-1].g_last.co_q;
  assign O_OV    = g_st[NSLICE-1].g_last.ov_q;

endmodule

// File: tb/tb_cy8_pipe_addsub.sv
// Bench for cy8_pipe_addsub: arithmetic reference model plus expectation queue, directed corners and random traffic.
module tb_cy8_pipe_addsub;

  localparam int WIDTH  = 32;
  localparam int NSLICE = WIDTH / 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             I_VALID;
  logic             I_READY;
  logic             I_SUB;
  logic             I_CI;
  logic [WIDTH-1:0] I_A;
  logic [WIDTH-1:0] I_B;
  logic             O_VALID;
  logic             O_READY;
  logic [WIDTH-1:0] O_SUM;
  logic             O_CO;
  logic             O_OV;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;
  } res_t;

  res_t exp_q[$];
  res_t e_h;
  int   out_cycs[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cy8_pipe_addsub #(.WIDTH(WIDTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .I_SUB   (I_SUB),
    .I_CI    (I_CI),
    .I_A     (I_A),
    .I_B     (I_B),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .O_SUM   (O_SUM),
    .O_CO    (O_CO),
    .O_OV    (O_OV)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Plain two's-complement arithmetic: add carries in CI, sub borrows CI; CO=1 means carry / no borrow.
  function automatic res_t model(input logic sub, input logic ci,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t         r;
    logic [WIDTH:0] full;
    logic [WIDTH:0] cext;
    cext = {{WIDTH{1'b0}}, ci};
    if (!sub) begin
      full  = {1'b0, a} + {1'b0, b} + cext;
      r.sum = full[WIDTH-1:0];
      r.co  = full[WIDTH];
      r.ov  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full  = {1'b0, a} - {1'b0, b} - cext;
      r.sum = full[WIDTH-1:0];
      r.co  = ~full[WIDTH];
      r.ov  = (a[WIDTH-1] != b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(WIDTH-1){1'b0}}};
      3:       v = {1'b0, {(WIDTH-1){1'b1}}};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Single compare process: pops the model queue on every output transfer, pushes on every input transfer.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
    end else begin
      if (O_VALID && O_READY) begin
        out_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got sum %0h with nothing outstanding, expected no output", O_SUM);
        end else begin
          e_h = exp_q.pop_front();
          check("result", {30'd0, O_SUM, O_CO, O_OV}, {30'd0, e_h.sum, e_h.co, e_h.ov});
        end
      end
      if (I_VALID && I_READY)
        exp_q.push_back(model(I_SUB, I_CI, I_A, I_B));
    end
  end

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check(nm, exp_q.size(), 0);
  endtask

  // One isolated transaction on an idle pipe: O_VALID must rise exactly NSLICE cycles after acceptance.
  task automatic directed(input string nm, input logic sub, input logic ci,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] esum, input logic eco, input logic eov);
    @(posedge CLK); #1;
    I_VALID = 1'b1; I_SUB = sub; I_CI = ci; I_A = a; I_B = b;
    @(posedge CLK); #1;
    I_VALID = 1'b0;
    for (int c = 1; c < NSLICE; c++) begin
      @(negedge CLK);
      check({nm, "_early_valid"}, O_VALID, 0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check({nm, "_valid"}, O_VALID, 1);
    check({nm, "_sum"},   O_SUM,   esum);
    check({nm, "_co"},    O_CO,    eco);
    check({nm, "_ov"},    O_OV,    eov);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; I_VALID = 1'b0; I_SUB = 1'b0; I_CI = 1'b0; I_A = '0; I_B = '0; O_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_valid", O_VALID, 0);
    check("rst_sum",   O_SUM,   0);
    check("rst_co",    O_CO,    0);
    check("rst_ov",    O_OV,    0);
    check("rst_irdy",  I_READY, 1);
    @(posedge CLK); #1 O_READY = 1'b1;

    directed("add_ff_1",    1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
    directed("add_ripple",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    directed("sub_borrow",  1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    directed("sub_ovf",     1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("add_ci",      1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    directed("sub_bin",     1'b1, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0);
    drain("drain_directed", 20);

    // back-to-back alternating add/sub
    out_cycs.delete();
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      I_VALID = 1'b1; I_SUB = i[0]; I_CI = 1'($urandom_range(0, 1));
      I_A = pick_operand(); I_B = pick_operand();
      @(negedge CLK);
      check("stream_irdy", I_READY, 1);
    end
    @(posedge CLK); #1 I_VALID = 1'b0;
    drain("drain_stream", 40);
    check("stream_count", out_cycs.size(), 16);
    if (out_cycs.size() == 16)
      check("stream_contig", out_cycs[15] - out_cycs[0], 15);

    // fill the pipe, then hold O_READY low for 5 cycles
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      I_VALID = 1'b1; I_SUB = 1'($urandom_range(0, 1)); I_CI = 1'($urandom_range(0, 1));
      I_A = pick_operand(); I_B = pick_operand();
    end
    O_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_irdy",  I_READY, 0);
      check("stall_valid", O_VALID, 1);
      if (exp_q.size() > 0)
        check("stall_hold", {30'd0, O_SUM, O_CO, O_OV}, {30'd0, exp_q[0].sum, exp_q[0].co, exp_q[0].ov});
      else
        check("stall_pending", exp_q.size(), NSLICE);
      @(posedge CLK); #1;
    end
    O_READY = 1'b1;
    @(posedge CLK); #1 I_VALID = 1'b0;
    drain("drain_stall", 40);

    // reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      I_VALID = 1'b1; I_SUB = 1'b0; I_CI = 1'b0; I_A = pick_operand(); I_B = pick_operand();
    end
    @(posedge CLK); #1;
    I_VALID = 1'b0; RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("post_rst_valid", O_VALID, 0);
    end
    directed("after_rst", 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
    drain("drain_rst", 20);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      O_READY = ($urandom_range(0, 3) != 0);
      I_VALID = ($urandom_range(0, 3) != 0);
      I_SUB   = 1'($urandom_range(0, 1));
      I_CI    = 1'($urandom_range(0, 1));
      I_A     = pick_operand();
      I_B     = pick_operand();
    end
    @(posedge CLK); #1;
    I_VALID = 1'b0; O_READY = 1'b1;
    drain("drain_random", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
